// File: rtl/digital_tube_driver.sv
// Memory-mapped 8-digit common-anode seven-segment scan driver (DATA at BASE_ADDR, CTRL at +4).
// Define TUBE_BLINK_EN to add the blink counter and the CTRL[2] blink enable.
module digital_tube_driver #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F50,
  parameter int unsigned SCAN_DIV  = 50000
`ifdef TUBE_BLINK_EN
  ,
  parameter int unsigned BLINK_DIV = 250
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic [7:0]  seg_sel,
  output logic [7:0]  seg_data
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  logic          cs;
  logic [31:0]   data_q, data_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic          step;
  logic          phase;
  logic          blink_wr;

  assign cs   = (Addr >= BASE_ADDR) && (Addr <= BASE_ADDR + 32'd7);
  assign step = (presc_q == PRESC_LAST);

`ifdef TUBE_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  assign blink_wr = Din[2];
  assign phase    = phase_q;

  // Blink counter advances once per digit step, so a phase lasts BLINK_DIV digit steps.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (step) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  assign blink_wr = 1'b0;
  assign phase    = 1'b0;
`endif

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (WE && cs) begin
      if (Addr[2]) ctrl_d = {blink_wr, Din[1:0]};
      else         data_d = Din;
    end
  end

  always_comb begin
    Dout = 32'd0;
    if (cs) Dout = Addr[2] ? {29'd0, ctrl_q} : data_q;
  end

  // Scan runs regardless of EN so re-enabling resumes at the current digit.
  assign presc_d = step ? '0 : presc_q + 1'b1;
  assign idx_d   = step ? idx_q + 3'd1 : idx_q;

  logic [31:0] nib_sh;
  logic        blank_all;
  logic        blank_dig;

  // nib_sh == 0 means every digit from idx upward is zero, i.e. a leading zero.
  always_comb begin
    nib_sh    = data_q >> {idx_q, 2'b00};
    blank_all = !ctrl_q[0] || (ctrl_q[2] && phase);
    blank_dig = blank_all || (ctrl_q[1] && (idx_q != 3'd0) && (nib_sh == 32'd0));
    sel_d     = blank_all ? 8'hFF : ~(8'b1 << idx_q);
    seg_d     = blank_dig ? 8'hFF : hex7(nib_sh[3:0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= 32'd0;
      ctrl_q  <= 3'b001;
      presc_q <= '0;
      idx_q   <= 3'd0;
      sel_q   <= 8'hFF;
      seg_q   <= 8'hFF;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign seg_sel  = sel_q;
  assign seg_data = seg_q;

endmodule

// File: tb/tb_digital_tube_driver.sv
// Directed bench for digital_tube_driver: scan order, hex decode, leading-zero suppress,
// enable, address decode, reset and (with TUBE_BLINK_EN) blinking.
module tb_digital_tube_driver;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Addr = 32'd0;
  logic        WE = 1'b0;
  logic [31:0] Din = 32'd0;
  logic [31:0] Dout;
  logic [7:0]  seg_sel;
  logic [7:0]  seg_data;

  int n_cmp = 0;
  int n_bad = 0;
  int ecount = 0;

  typedef struct {
    logic [7:0] sel;
    logic [7:0] dat;
    bit         chk_dat;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  digital_tube_driver #(
    .BASE_ADDR(32'h0000_7F50),
    .SCAN_DIV(SD)
`ifdef TUBE_BLINK_EN
    ,
    .BLINK_DIV(2)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .Addr(Addr),
    .WE(WE),
    .Din(Din),
    .Dout(Dout),
    .seg_sel(seg_sel),
    .seg_data(seg_data)
  );

  always #5 clk = ~clk;

  // Edges since reset release; drives the expected digit index and blink phase.
  always @(posedge clk or negedge reset) begin
    if (!reset) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] expv);
    Addr = a;
    #1;
    chk(tag, Dout, expv);
    Addr = 32'd0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    Addr = a;
    Din  = v;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Addr = 32'd0;
    Din  = 32'd0;
  endtask

  // Push the expected display for the next edge, then pop and compare after it.
  task automatic expect_cycles(input string tag, input int n, input logic [31:0] d,
                               input logic [2:0] c);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      exp_t got;
      int idx;
      int ph;
      logic [31:0] sh;
      logic [7:0] one;
      bit blank_all;
      bit sup;
      idx = (ecount / SD) % 8;
      ph  = (ecount / (2 * SD)) % 2;
      sh  = d >> (4 * idx);
      one = 8'd1 << idx;
      blank_all = (c[0] == 1'b0) || (c[2] == 1'b1 && ph == 1);
      sup = (idx != 0) && (c[1] == 1'b1) && (sh == 32'd0);
      e.sel = blank_all ? 8'hFF : (8'hFF ^ one);
      e.dat = sup ? 8'hFF : hex_tab[sh[3:0]];
      e.chk_dat = !blank_all;
      sbq.push_back(e);
      @(negedge clk);
      got = sbq.pop_front();
      chk({tag, "_sel"}, {24'd0, seg_sel}, {24'd0, got.sel});
      if (got.chk_dat) chk({tag, "_data"}, {24'd0, seg_data}, {24'd0, got.dat});
    end
  endtask

  initial begin
    // Power-on reset
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sel", {24'd0, seg_sel}, 32'h0000_00FF);
    chk("rst_data", {24'd0, seg_data}, 32'h0000_00FF);
    rd_check("rst_ctrl", 32'h0000_7F54, 32'd1);
    rd_check("rst_dat", 32'h0000_7F50, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Full scan of all 16 glyph positions and the 7 -> 0 wrap
    bus_write(32'h0000_7F50, 32'h89AB_CDEF);
    rd_check("rd_data", 32'h0000_7F50, 32'h89AB_CDEF);
    expect_cycles("scan", 36, 32'h89AB_CDEF, 3'b001);
    bus_write(32'h0000_7F50, 32'h0123_4567);
    expect_cycles("scan2", 32, 32'h0123_4567, 3'b001);

    // Leading-zero suppression
    bus_write(32'h0000_7F54, 32'd3);
    bus_write(32'h0000_7F50, 32'h0000_0100);
    expect_cycles("lzs", 36, 32'h0000_0100, 3'b011);
    bus_write(32'h0000_7F50, 32'd0);
    expect_cycles("lzs0", 32, 32'd0, 3'b011);

    // Disable blanks but keeps scanning; re-enable resumes at the running index
    bus_write(32'h0000_7F54, 32'd0);
    bus_write(32'h0000_7F50, 32'h1234_5678);
    rd_check("rd_ctrl_off", 32'h0000_7F54, 32'd0);
    expect_cycles("off", 10, 32'h1234_5678, 3'b000);
    bus_write(32'h0000_7F54, 32'd1);
    expect_cycles("resume", 20, 32'h1234_5678, 3'b001);

    // Address decode at window edges
    bus_write(32'h0000_7F58, 32'hFFFF_FFFF);
    bus_write(32'h0000_7F4C, 32'h0000_0000);
    rd_check("rd_out_hi", 32'h0000_7F58, 32'd0);
    rd_check("rd_out_lo", 32'h0000_7F4C, 32'd0);
    rd_check("rd_keep_dat", 32'h0000_7F50, 32'h1234_5678);
    rd_check("rd_keep_ctrl", 32'h0000_7F54, 32'd1);
    bus_write(32'h0000_7F57, 32'd3);
    rd_check("rd_ctrl_7f57", 32'h0000_7F54, 32'd3);
    rd_check("rd_ctrl_hi_alias", 32'h0000_7F57, 32'd3);
    bus_write(32'h0000_7F51, 32'hCAFE_F00D);
    rd_check("rd_dat_7f51", 32'h0000_7F50, 32'hCAFE_F00D);
    expect_cycles("alias", 12, 32'hCAFE_F00D, 3'b011);

    // Blink control
    bus_write(32'h0000_7F54, 32'd5);
`ifdef TUBE_BLINK_EN
    rd_check("rd_ctrl_blink", 32'h0000_7F54, 32'd5);
    expect_cycles("blink", 40, 32'hCAFE_F00D, 3'b101);
`else
    rd_check("rd_ctrl_blink", 32'h0000_7F54, 32'd1);
    expect_cycles("noblink", 40, 32'hCAFE_F00D, 3'b001);
`endif

    // Asynchronous reset in the middle of a scan
    bus_write(32'h0000_7F54, 32'd1);
    expect_cycles("pre_rst", 6, 32'hCAFE_F00D, 3'b001);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_sel", {24'd0, seg_sel}, 32'h0000_00FF);
    chk("mid_rst_data", {24'd0, seg_data}, 32'h0000_00FF);
    @(negedge clk);
    rd_check("mid_rst_ctrl", 32'h0000_7F54, 32'd1);
    rd_check("mid_rst_dat", 32'h0000_7F50, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    expect_cycles("post_rst", 12, 32'd0, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
